// File: rtl/layer_argmax_8_if.sv
// Stream interface for layer_argmax_8.
//   Element side : s_valid / s_ready / data_in  (one signed T-bit element per transfer)
//   Result side  : m_valid / m_ready / data_out (IW-bit index) / max_out (signed T-bit value)
// Modports:
//   slave  - the argmax block (consumes elements, produces the result)
//   master - the environment (produces elements, consumes the result)
interface layer_argmax_8_if #(
   parameter int T  = 8,
   parameter int IW = 3
);
   logic          s_valid;
   logic          s_ready;
   logic [T-1:0]  data_in;
   logic          m_valid;
   logic          m_ready;
   logic [IW-1:0] data_out;
   logic [T-1:0]  max_out;

   modport slave (
      input  s_valid, data_in, m_ready,
      output s_ready, m_valid, data_out, max_out
   );

   modport master (
      output s_valid, data_in, m_ready,
      input  s_ready, m_valid, data_out, max_out
   );
endinterface

// File: rtl/layer_argmax_8.sv
// layer_argmax_8: collects an N-element vector of signed T-bit elements and reports
// the index and value of the largest element (lowest index wins ties).
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high; discards any partial vector
//   bus   - layer_argmax_8_if.slave
//             s_valid/s_ready/data_in  : element stream in (s_ready = 1 only while accumulating)
//             m_valid/m_ready          : result handshake, result held until taken
//             data_out                 : index of the maximum element
//             max_out                  : value of the maximum element
module layer_argmax_8 #(
   parameter int T  = 8,
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   layer_argmax_8_if.slave bus
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   state_e                state_q,    state_d;
   logic [IW-1:0]         elem_cnt_q, elem_cnt_d;
   logic signed [T-1:0]   best_val_q, best_val_d;
   logic [IW-1:0]         best_idx_q, best_idx_d;
   logic                  m_valid_q,  m_valid_d;
   logic [IW-1:0]         data_out_q, data_out_d;
   logic signed [T-1:0]   max_out_q,  max_out_d;

   logic                  accept;
   logic                  last_elem;
   logic                  take_new;
   logic signed [T-1:0]   cand_val;
   logic [IW-1:0]         cand_idx;

   always_comb begin
      state_d    = state_q;
      elem_cnt_d = elem_cnt_q;
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      m_valid_d  = m_valid_q;
      data_out_d = data_out_q;
      max_out_d  = max_out_q;

      accept    = bus.s_valid && (state_q == ACCUM);
      last_elem = (elem_cnt_q == IW'(N - 1));
      // Element 0 always seeds the running max; later ones must be strictly greater,
      // so ties keep the earlier index.
      take_new  = (elem_cnt_q == '0) || ($signed(bus.data_in) > best_val_q);
      cand_val  = take_new ? $signed(bus.data_in) : best_val_q;
      cand_idx  = take_new ? elem_cnt_q : best_idx_q;

      case (state_q)
         ACCUM: begin
            if (accept) begin
               best_val_d = cand_val;
               best_idx_d = cand_idx;
               if (last_elem) begin
                  // The final element takes part in the compare before the result is latched.
                  data_out_d = cand_idx;
                  max_out_d  = cand_val;
                  m_valid_d  = 1'b1;
                  elem_cnt_d = '0;
                  state_d    = HOLD;
               end else begin
                  elem_cnt_d = elem_cnt_q + IW'(1);
               end
            end
         end
         HOLD: begin
            if (m_valid_q && bus.m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ACCUM;
         elem_cnt_q <= '0;
         best_val_q <= '0;
         best_idx_q <= '0;
         m_valid_q  <= 1'b0;
         data_out_q <= '0;
         max_out_q  <= '0;
      end else begin
         state_q    <= state_d;
         elem_cnt_q <= elem_cnt_d;
         best_val_q <= best_val_d;
         best_idx_q <= best_idx_d;
         m_valid_q  <= m_valid_d;
         data_out_q <= data_out_d;
         max_out_q  <= max_out_d;
      end
   end

   assign bus.s_ready  = (state_q == ACCUM);
   assign bus.m_valid  = m_valid_q;
   assign bus.data_out = data_out_q;
   assign bus.max_out  = max_out_q;

endmodule

// File: tb/tb_layer_argmax_8.sv
// Directed testbench for layer_argmax_8: hand-computed argmax results, hold under
// back-pressure, reset mid-vector and back-to-back vectors with random s_valid gaps.
module tb_layer_argmax_8;

   typedef logic signed [7:0] vec_t [8];

   logic clk;
   logic reset;
   int unsigned n_cmp;
   int unsigned n_err;

   layer_argmax_8_if #(.T(8), .IW(3)) bus ();

   layer_argmax_8 #(.T(8), .N(8), .IW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (actual running, required finished)");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      if (observed !== expected) begin
         n_err++;
         $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", tag, observed, observed, expected, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one element after 'gap' idle cycles; waits (bounded) for s_ready.
   task automatic push(input logic signed [7:0] v, input int unsigned gap);
      int unsigned n;
      bus.s_valid = 1'b0;
      for (int unsigned g = 0; g < gap; g++) tick();
      n = 0;
      while (!bus.s_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus.s_ready) check_eq("s_ready_wait_timeout", 32'(bus.s_ready), 32'd1);
      bus.s_valid = 1'b1;
      bus.data_in = v;
      tick();
      bus.s_valid = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [2:0] idx, input logic [7:0] val);
      check_eq({tag, "_m_valid"},  32'(bus.m_valid),  32'd1);
      check_eq({tag, "_data_out"}, 32'(bus.data_out), 32'(idx));
      check_eq({tag, "_max_out"},  32'(bus.max_out),  32'(val));
      check_eq({tag, "_s_ready"},  32'(bus.s_ready),  32'd0);
   endtask

   task automatic release_result(input string tag, input logic [2:0] idx, input logic [7:0] val);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      check_eq({tag, "_rel_m_valid"},  32'(bus.m_valid),  32'd0);
      check_eq({tag, "_rel_s_ready"},  32'(bus.s_ready),  32'd1);
      check_eq({tag, "_rel_data_out"}, 32'(bus.data_out), 32'(idx));
      check_eq({tag, "_rel_max_out"},  32'(bus.max_out),  32'(val));
   endtask

   task automatic run_vec(input string tag, input vec_t v, input bit gaps,
                          input logic [2:0] idx, input logic [7:0] val);
      for (int i = 0; i < 7; i++) push(v[i], gaps ? $urandom_range(0, 2) : 0);
      check_eq({tag, "_no_early_valid"}, 32'(bus.m_valid), 32'd0);
      push(v[7], gaps ? $urandom_range(0, 2) : 0);
      expect_result(tag, idx, val);
   endtask

   initial begin
      vec_t v;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.s_valid = 1'b0;
      bus.data_in = '0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check_eq("rst_m_valid",  32'(bus.m_valid),  32'd0);
      check_eq("rst_s_ready",  32'(bus.s_ready),  32'd1);
      check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
      check_eq("rst_max_out",  32'(bus.max_out),  32'd0);

      // 1: [3,-1,7,7,2,0,-5,1] -> index 2, value 7 (tie with index 3 keeps 2)
      v = '{8'sd3, -8'sd1, 8'sd7, 8'sd7, 8'sd2, 8'sd0, -8'sd5, 8'sd1};
      run_vec("t1", v, 1'b0, 3'd2, 8'd7);
      release_result("t1", 3'd2, 8'd7);

      // 2: all -128 -> index 0, value -128
      v = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      run_vec("t2", v, 1'b0, 3'd0, 8'h80);
      release_result("t2", 3'd0, 8'h80);

      // 3: last element wins -> index 7, value 5
      v = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd5};
      run_vec("t3", v, 1'b0, 3'd7, 8'd5);

      // 4: back-pressure with a pending element held on s_valid
      bus.s_valid = 1'b1;
      bus.data_in = 8'sd42;
      for (int c = 0; c < 5; c++) begin
         check_eq("t4_hold_m_valid",  32'(bus.m_valid),  32'd1);
         check_eq("t4_hold_data_out", 32'(bus.data_out), 32'd7);
         check_eq("t4_hold_max_out",  32'(bus.max_out),  32'd5);
         check_eq("t4_hold_s_ready",  32'(bus.s_ready),  32'd0);
         tick();
      end
      release_result("t4", 3'd7, 8'd5);
      // The held 42 is accepted now as element 0 of the next vector.
      tick();
      bus.s_valid = 1'b0;
      for (int i = 1; i < 8; i++) push(8'(i), 0);
      expect_result("t4_next", 3'd0, 8'd42);
      release_result("t4_next", 3'd0, 8'd42);

      // 5: reset after four 9s, then [1..8] -> index 7, value 8
      for (int i = 0; i < 4; i++) push(8'sd9, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("t5_rst_m_valid",  32'(bus.m_valid),  32'd0);
      check_eq("t5_rst_s_ready",  32'(bus.s_ready),  32'd1);
      check_eq("t5_rst_data_out", 32'(bus.data_out), 32'd0);
      check_eq("t5_rst_max_out",  32'(bus.max_out),  32'd0);
      v = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
      run_vec("t5", v, 1'b0, 3'd7, 8'd8);
      release_result("t5", 3'd7, 8'd8);

      // 6: back-to-back vectors, random gaps, m_ready held high
      bus.m_ready = 1'b1;
      v = '{-8'sd3, 8'sd5, 8'h80, 8'sd127, 8'sd127, 8'sd0, -8'sd1, 8'sd4};
      run_vec("t6a", v, 1'b1, 3'd3, 8'd127);
      v = '{8'sd10, -8'sd20, 8'sd10, 8'sd3, 8'sd10, -8'sd7, 8'sd9, 8'sd10};
      run_vec("t6b", v, 1'b1, 3'd0, 8'd10);
      tick();
      check_eq("t6_done_m_valid", 32'(bus.m_valid), 32'd0);
      check_eq("t6_done_s_ready", 32'(bus.s_ready), 32'd1);
      bus.m_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
